// File: rtl/pc_seq_pkg.sv
// Shared op codes and FSM state encoding for the PC sequencer.
// HALT is only reachable when PC_SEQ_HALT_ON_RAS_ERR_EN is defined.
package pc_seq_pkg;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_BRZ  = 3'd1;
  localparam logic [2:0] OP_BRNZ = 3'd2;
  localparam logic [2:0] OP_JUMP = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: small LIFO, one push or one pop per cycle.
// Push when full and pop when empty are dropped; the caller flags them.
module pc_ras #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_top,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_wr_idx  = r_cnt[AW-1:0];
  assign w_rd_idx  = w_wr_idx - AW'(1);
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_top     = r_mem[w_rd_idx];
  assign o_count   = r_cnt;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty && !i_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_do_push) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (w_do_pop) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC owner and fetch sequencer: FETCH/EXEC FSM, next-PC mux, RAS.
// Define PC_SEQ_HALT_ON_RAS_ERR_EN to halt on RAS overflow/underflow.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W    = 16,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [ADDR_W-1:0] op_target,
  input  logic              cond_zero,
  output logic [ADDR_W-1:0] pc,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int RAS_CW = $clog2(RAS_DEPTH) + 1;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_fetch_req;
  logic                r_op_ready;
  logic                r_ovf;
  logic                r_unf;

  logic                w_accept;
  logic                w_ack;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [ADDR_W-1:0]   w_next_pc;
  logic                w_is_brz;
  logic                w_is_brnz;
  logic                w_is_jump;
  logic                w_is_call;
  logic                w_is_ret;
  logic                w_ovf_err;
  logic                w_unf_err;
  logic                w_err;
  logic                w_go_halt;
  logic                w_push;
  logic                w_pop;
  logic [ADDR_W-1:0]   w_ras_top;
  logic                w_ras_full;
  logic                w_ras_empty;
  logic [RAS_CW-1:0]   w_ras_cnt;

  assign pc            = r_pc;
  assign fetch_addr    = r_pc;
  assign fetch_req     = r_fetch_req;
  assign op_ready      = r_op_ready;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

  assign w_accept  = (r_state == ST_EXEC) && r_op_ready && op_valid;
  assign w_ack     = (r_state == ST_FETCH) && r_fetch_req && fetch_ack;
  assign w_pc_inc  = r_pc + ADDR_W'(1);

  assign w_is_brz  = (op_code == OP_BRZ);
  assign w_is_brnz = (op_code == OP_BRNZ);
  assign w_is_jump = (op_code == OP_JUMP);
  assign w_is_call = (op_code == OP_CALL);
  assign w_is_ret  = (op_code == OP_RET);

  assign w_ovf_err = w_is_call && w_ras_full;
  assign w_unf_err = w_is_ret && w_ras_empty;
  assign w_err     = w_accept && (w_ovf_err || w_unf_err);
  assign w_push    = w_accept && w_is_call && !w_ras_full;
  assign w_pop     = w_accept && w_is_ret && !w_ras_empty;

`ifdef PC_SEQ_HALT_ON_RAS_ERR_EN
  assign w_go_halt = w_err;
`else
  assign w_go_halt = 1'b0;
`endif

  // Opcodes 6 and 7 fall through to the sequential default.
  always_comb begin
    w_next_pc = w_pc_inc;
    unique case (1'b1)
      w_is_brz:  if (cond_zero) w_next_pc = op_target;
      w_is_brnz: if (!cond_zero) w_next_pc = op_target;
      w_is_jump: w_next_pc = op_target;
      w_is_call: w_next_pc = op_target;
      w_is_ret:  if (!w_ras_empty) w_next_pc = w_ras_top;
      default:   w_next_pc = w_pc_inc;
    endcase
  end

  always_comb begin
    assert (w_ras_cnt <= RAS_CW'(RAS_DEPTH));
  end

  pc_ras #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_pc_inc),
    .o_top   (w_ras_top),
    .o_full  (w_ras_full),
    .o_empty (w_ras_empty),
    .o_count (w_ras_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_fetch_req <= 1'b0;
      r_op_ready  <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ovf <= r_ovf | w_ovf_err;
        r_unf <= r_unf | w_unf_err;
      end
      unique case (r_state)
        ST_FETCH: begin
          if (w_ack) begin
            r_state     <= ST_EXEC;
            r_fetch_req <= 1'b0;
            r_op_ready  <= 1'b1;
          end else begin
            r_fetch_req <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (w_accept && w_go_halt) begin
            r_state    <= ST_HALT;
            r_op_ready <= 1'b0;
          end else if (w_accept) begin
            r_pc        <= w_next_pc;
            r_state     <= ST_FETCH;
            r_fetch_req <= 1'b1;
            r_op_ready  <= 1'b0;
          end
        end
        ST_HALT: begin
          r_fetch_req <= 1'b0;
          r_op_ready  <= 1'b0;
        end
        default: begin
          r_state     <= ST_FETCH;
          r_fetch_req <= 1'b0;
          r_op_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected fetch addresses are queued
// when an op is issued and popped when the DUT raises fetch_req.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int DEPTH = 8;
`ifdef PC_SEQ_HALT_ON_RAS_ERR_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [15:0] op_target;
  logic        cond_zero;
  logic [15:0] pc;
  logic        ras_overflow;
  logic        ras_underflow;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [15:0] m_ras[$];
  logic [15:0] m_pc;
  logic        m_ovf;
  logic        m_unf;
  logic        m_halted;

  pc_sequencer #(
    .ADDR_W    (16),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_ack     (fetch_ack),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_code       (op_code),
    .op_target     (op_target),
    .cond_zero     (cond_zero),
    .pc            (pc),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    m_pc = 16'h0000;
    m_ras.delete();
    exp_q.delete();
    exp_q.push_back(16'h0000);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_ack = 1'b0;
    op_valid = 1'b0;
    op_code = OP_NEXT;
    op_target = 16'h0;
    cond_zero = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic fetch(input int dly);
    int n;
    logic [15:0] e;
    if (m_halted) return;
    n = 0;
    while (fetch_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout: got req=%b exp 1", fetch_req);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL fetch_sb: got addr=%h exp <none>", fetch_addr);
      return;
    end
    e = exp_q.pop_front();
    if (fetch_addr !== e) begin
      errors++;
      $display("FAIL fetch_addr: got %h exp %h", fetch_addr, e);
    end
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== e || op_ready !== 1'b0) begin
        errors++;
        $display("FAIL fetch_hold: got req=%b addr=%h rdy=%b exp 1 %h 0",
                 fetch_req, fetch_addr, op_ready, e);
      end
    end
    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
    checks++;
    if (op_ready !== 1'b1 || fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done: got rdy=%b req=%b exp 1 0",
               op_ready, fetch_req);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] tgt,
                       input logic cz);
    logic [15:0] nxt;
    logic err;
    if (m_halted) return;
    nxt = m_pc + 16'd1;
    err = 1'b0;
    case (op)
      OP_BRZ:  if (cz) nxt = tgt;
      OP_BRNZ: if (!cz) nxt = tgt;
      OP_JUMP: nxt = tgt;
      OP_CALL: begin
        if (m_ras.size() < DEPTH) m_ras.push_back(m_pc + 16'd1);
        else begin err = 1'b1; m_ovf = 1'b1; end
        nxt = tgt;
      end
      OP_RET: begin
        if (m_ras.size() == 0) begin err = 1'b1; m_unf = 1'b1; end
        else nxt = m_ras.pop_back();
      end
      default: ;
    endcase
    op_code = op;
    op_target = tgt;
    cond_zero = cz;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    if (HALT_EN && err) begin
      m_halted = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (pc !== m_pc || fetch_req !== 1'b0 || op_ready !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold: got pc=%h req=%b rdy=%b exp %h 0 0",
                 pc, fetch_req, op_ready, m_pc);
      end
    end else begin
      m_pc = nxt;
      exp_q.push_back(nxt);
      checks++;
      if (pc !== nxt) begin
        errors++;
        $display("FAIL issue_pc op=%0d: got %h exp %h", op, pc, nxt);
      end
      checks++;
      if (op_ready !== 1'b0 || fetch_req !== 1'b1) begin
        errors++;
        $display("FAIL issue_hs: got rdy=%b req=%b exp 0 1",
                 op_ready, fetch_req);
      end
    end
    checks++;
    if (ras_overflow !== m_ovf || ras_underflow !== m_unf) begin
      errors++;
      $display("FAIL ras_flags: got ovf=%b unf=%b exp %b %b",
               ras_overflow, ras_underflow, m_ovf, m_unf);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 16'h0 || fetch_req !== 1'b0 || op_ready !== 1'b0 ||
        ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got pc=%h req=%b rdy=%b ovf=%b unf=%b exp 0",
               pc, fetch_req, op_ready, ras_overflow, ras_underflow);
    end
  endtask

  task automatic test_next();
    fetch(0);
    issue(OP_NEXT, 16'h0, 1'b0);
    fetch(0);
    issue(3'd6, 16'h77, 1'b1);
    fetch(0);
    issue(3'd7, 16'h55, 1'b0);
    fetch(0);
  endtask

  task automatic test_branch();
    issue(OP_JUMP, 16'h0005, 1'b0);
    fetch(0);
    issue(OP_BRZ, 16'h0040, 1'b1);
    fetch(0);
    issue(OP_JUMP, 16'h0005, 1'b0);
    fetch(0);
    issue(OP_BRZ, 16'h0040, 1'b0);
    fetch(0);
    issue(OP_BRNZ, 16'h0080, 1'b0);
    fetch(0);
    issue(OP_BRNZ, 16'h0090, 1'b1);
    fetch(0);
  endtask

  task automatic test_call_ret();
    issue(OP_JUMP, 16'h0010, 1'b0);
    fetch(0);
    issue(OP_CALL, 16'h0100, 1'b0);
    fetch(0);
    issue(OP_RET, 16'h0000, 1'b0);
    fetch(0);
  endtask

  task automatic test_wrap_and_stall();
    issue(OP_JUMP, 16'hFFFF, 1'b0);
    fetch(0);
    issue(OP_NEXT, 16'h0, 1'b0);
    fetch(4);
    fetch_ack = 1'b1;
    repeat (2) @(negedge clk);
    fetch_ack = 1'b0;
    checks++;
    if (op_ready !== 1'b1 || fetch_req !== 1'b0 || pc !== m_pc) begin
      errors++;
      $display("FAIL exec_idle: got rdy=%b req=%b pc=%h exp 1 0 %h",
               op_ready, fetch_req, pc, m_pc);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fetch(0);
    for (int i = 0; i < 9; i++) begin
      issue(OP_CALL, 16'(16'h0200 + 16'(i * 16)), 1'b0);
      fetch(0);
    end
    for (int i = 0; i < 8; i++) begin
      issue(OP_RET, 16'h0, 1'b0);
      fetch(0);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    fetch(0);
    issue(OP_NEXT, 16'h0, 1'b0);
    fetch(0);
    issue(OP_RET, 16'h0, 1'b0);
    fetch(0);
  endtask

  task automatic test_reset_mid_fetch();
    issue(OP_NEXT, 16'h0, 1'b0);
    reset = 1'b1;
    fetch_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (pc !== 16'h0 || fetch_req !== 1'b0 || op_ready !== 1'b0 ||
        ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got pc=%h req=%b rdy=%b ovf=%b unf=%b exp 0",
               pc, fetch_req, op_ready, ras_overflow, ras_underflow);
    end
    reset = 1'b0;
    fetch_ack = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b1 || op_ready !== 1'b0 || pc !== 16'h0) begin
      errors++;
      $display("FAIL rst_after: got req=%b rdy=%b pc=%h exp 1 0 0000",
               fetch_req, op_ready, pc);
    end
    fetch(0);
    issue(OP_NEXT, 16'h0, 1'b0);
    fetch(0);
  endtask

  initial begin
    test_reset();
    test_next();
    test_branch();
    test_call_ret();
    test_wrap_and_stall();
    test_overflow();
    test_underflow();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter for the stack processor and sequences instruction fetch.
- Computes next PC with an internal +1 incrementer and selects between sequential, branch, jump, call and return targets.
- Keeps a small return-address stack (RAS) for call/return.
- Sits between the control unit (which issues PC ops) and instruction memory (req/ack fetch handshake).

Parameters:
- ADDR_W, 16, PC/address width; memory is word-addressed, so sequential step is +1.
- RAS_DEPTH, 8, return-address stack entries (power of 2, >=2).
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- fetch_req  out  1  instruction fetch request to imem
- fetch_addr  out  ADDR_W  address for fetch; equals pc
- fetch_ack  in  1  imem has returned the instruction for fetch_addr
- op_valid  in  1  control unit presents a PC op
- op_ready  out  1  sequencer accepts op this cycle
- op_code  in  3  0 NEXT, 1 BRZ, 2 BRNZ, 3 JUMP, 4 CALL, 5 RET, 6-7 treated as NEXT
- op_target  in  ADDR_W  branch/jump/call target
- cond_zero  in  1  top-of-stack == 0 flag, sampled with op
- pc  out  ADDR_W  current PC
- ras_overflow  out  1  sticky: CALL issued with RAS full
- ras_underflow  out  1  sticky: RET issued with RAS empty

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high.
- Reset values: pc=RESET_PC, state=FETCH, fetch_req=0, op_ready=0, RAS count=0, ras_overflow=0, ras_underflow=0.
- FETCH state:
  - fetch_req=1 and fetch_addr=pc, held stable until fetch_ack.
  - On fetch_ack, go to EXEC next cycle.
  - fetch_req drops the cycle after ack is seen.
- EXEC state:
  - op_ready=1.
  - On op_valid&op_ready, pc updates next edge and state returns to FETCH:
    - NEXT: pc+1.
    - BRZ: op_target if cond_zero, else pc+1.
    - BRNZ: op_target if !cond_zero, else pc+1.
    - JUMP: op_target.
    - CALL: push pc+1, then pc=op_target.
    - RET: pop, pc=popped value.
  - Without op_valid, stay in EXEC with pc unchanged.
- Latency: op accepted at edge N, new pc visible N+1, fetch_req asserted N+1. Minimum two cycles per instruction with a single-cycle ack.
- Arithmetic: pc+1 wraps modulo 2^ADDR_W (16'hFFFF -> 16'h0000, no flag).
- RAS boundaries:
  - CALL when full: target still taken, push dropped, ras_overflow set.
  - RET when empty: pc=pc+1, ras_underflow set.
  - Flags clear only on reset.
- Reset mid-fetch or mid-op overrides everything: pending fetch abandoned, and any ack arriving in the reset cycle is ignored.
- fetch_ack outside FETCH is ignored.

Optional Feature:
- Macro: PC_SEQ_HALT_ON_RAS_ERR_EN.
- Defined:
  - An overflow or underflow moves the FSM to HALT: fetch_req=0, op_ready=0, pc frozen at the faulting op's pc.
  - Only reset exits HALT. The erroring op's pc update is suppressed.
- Undefined: no HALT state; errors only set the sticky flags as above.

Decomposition:
- Package pc_seq_pkg holds op_code localparams (OP_NEXT..OP_RET) and state encoding (ST_FETCH, ST_EXEC, ST_HALT).
- One natural sub-module: pc_ras. A LIFO with push/pop, full/empty and count; one push or pop per cycle, never both.
- Top level holds the FSM, next-PC mux and +1 incrementer.

Test Plan:
- Reset then immediate ack, issue 3x NEXT -> fetch_addr sequence 0,1,2,3; pc=3.
- pc=5, BRZ target 0x40: cond_zero=1 -> pc=0x40; repeat with cond_zero=0 -> pc=6.
- CALL 0x100 at pc=0x10, then RET -> pc=0x100, then 0x11; RAS count returns to 0.
- Nine nested CALLs (RAS_DEPTH=8) -> ras_overflow=1 on the 9th, target still taken. RET with empty RAS -> ras_underflow=1, pc=pc+1. With macro defined: FSM in HALT, fetch_req=0.
- pc=16'hFFFF, NEXT -> pc=16'h0000. fetch_ack delayed 4 cycles -> fetch_addr stable, op_ready=0 throughout.
- Assert reset while in FETCH with fetch_ack high -> pc=RESET_PC, no EXEC entry that cycle, flags cleared.
